// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, requester ids
// and default sizing.
package dmem_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam logic ID_LSU = 1'b0;
  localparam logic ID_DMA = 1'b1;

  localparam int DEFAULT_DEPTH    = 1024;
  localparam int DEFAULT_LOCK_MAX = 16;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone requester always wins, and on
// contention the port named by ptr wins.
module rr_pick2
  import dmem_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = (ptr == ID_DMA) ? 2'b10 : 2'b01;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the LSU and
// the loader/DMA, with locked bursts guarded by a watchdog.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int LOCK_MAX = DEFAULT_LOCK_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_we,
  input  logic [1:0]  req_lock,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  input  logic [31:0] req_wdata0,
  input  logic [31:0] req_wdata1,
  output logic [1:0]  req_ready,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        lock_abort
);

  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_MAX - 1);

  arb_state_t  state, state_next;
  logic        owner, owner_next;
  logic        rr_ptr, rr_next;
  logic [7:0]  lock_cnt, cnt_next;
  logic        abort_next;

  logic [1:0]  rr_grant;
  logic [1:0]  grant;
  logic        gid;
  logic        accept;
  logic [31:0] gaddr;
  logic [31:0] gwdata;
  logic        gwe;
  logic        in_range;

  rr_pick2 u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (rr_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= ID_LSU;
      rr_ptr     <= ID_LSU;
      lock_cnt   <= '0;
      lock_abort <= 1'b0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      rr_ptr     <= rr_next;
      lock_cnt   <= cnt_next;
      lock_abort <= abort_next;
    end
  end

  // The watchdog counts every locked cycle, beat or not; hitting the limit
  // without a clean release hands the memory back and flags the abort.
  always_comb begin
    state_next = state;
    owner_next = owner;
    rr_next    = rr_ptr;
    cnt_next   = lock_cnt;
    abort_next = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (accept) begin
          rr_next = ~gid;
          if (req_lock[gid]) begin
            state_next = ARB_LOCKED;
            owner_next = gid;
            cnt_next   = 8'd1;
          end
        end
      end
      ARB_LOCKED: begin
        if (accept && !req_lock[owner]) begin
          state_next = ARB_IDLE;
          rr_next    = ~owner;
          cnt_next   = '0;
        end else if (lock_cnt >= LOCK_LAST) begin
          state_next = ARB_IDLE;
          rr_next    = ~owner;
          cnt_next   = '0;
          abort_next = 1'b1;
        end else begin
          cnt_next = lock_cnt + 8'd1;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Grant and memory pins are combinational so an accepted beat reaches the
  // memory in the same cycle; reset silences everything.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (state == ARB_IDLE) begin
        grant = rr_grant;
      end else if (req_valid[owner]) begin
        grant = owner ? 2'b10 : 2'b01;
      end
    end
    gid       = grant[1];
    accept    = |grant;
    gaddr     = gid ? req_addr1 : req_addr0;
    gwdata    = gid ? req_wdata1 : req_wdata0;
    gwe       = req_we[gid];
    in_range  = gaddr < DEPTH_W;
    req_ready = grant;
    mem_a     = accept ? gaddr : '0;
    mem_wd    = accept ? gwdata : '0;
    mem_we    = accept & gwe & in_range;
  end

  // Read data is taken from the combinational memory port in the accept cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_id    <= accept & gid;
      rsp_err   <= accept & ~in_range;
      rsp_rdata <= (accept && !gwe && in_range) ? mem_rd : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a behavioural memory model
// (sync write, comb read, all-ones returned outside the array).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we, req_lock;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [1:0]  req_ready;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
  logic        rsp_valid, rsp_id, rsp_err, lock_abort;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(1024), .LOCK_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_lock   (req_lock),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .req_ready  (req_ready),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .lock_abort (lock_abort)
  );

  logic [31:0] mem [0:1023];

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[9:0]] <= mem_wd;
  end

  assign mem_rd = (mem_a < 32'd1024) ? mem[mem_a[9:0]] : 32'hFFFF_FFFF;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [1:0]  lock;
    logic [31:0] a0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [31:0] wd1;
    logic [1:0]  ready;
    logic        mwe;
    logic [31:0] ma;
    logic        rv;
    logic        rid;
    logic [31:0] rdata;
    logic        rerr;
    logic        abort;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] valid, input logic [1:0] we, input logic [1:0] lock,
                         input logic [31:0] a0, input logic [31:0] wd0,
                         input logic [31:0] a1, input logic [31:0] wd1,
                         input logic [1:0] ready, input logic mwe, input logic [31:0] ma,
                         input logic rv, input logic rid, input logic [31:0] rdata,
                         input logic rerr, input logic abort);
    vec_t v;
    v.valid = valid; v.we = we; v.lock = lock;
    v.a0 = a0; v.wd0 = wd0; v.a1 = a1; v.wd1 = wd1;
    v.ready = ready; v.mwe = mwe; v.ma = ma;
    v.rv = rv; v.rid = rid; v.rdata = rdata; v.rerr = rerr; v.abort = abort;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    req_valid  = v.valid;
    req_we     = v.we;
    req_lock   = v.lock;
    req_addr0  = v.a0;
    req_wdata0 = v.wd0;
    req_addr1  = v.a1;
    req_wdata1 = v.wd1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    //       valid  we     lock   a0    wd0        a1    wd1   | ready  we ma    rv id rdata  err abort
    // contention: alternating writes
    add_vec(2'b11, 2'b11, 2'b00, 28,   32'h1,     40,   32'h2, 2'b01, 1, 28,   0, 0, 0,     0, 0);
    add_vec(2'b11, 2'b11, 2'b00, 28,   32'h1,     40,   32'h2, 2'b10, 1, 40,   1, 0, 0,     0, 0);
    add_vec(2'b11, 2'b11, 2'b00, 28,   32'h5,     40,   32'h2, 2'b01, 1, 28,   1, 1, 0,     0, 0);
    add_vec(2'b11, 2'b11, 2'b00, 28,   32'h5,     40,   32'h2, 2'b10, 1, 40,   1, 0, 0,     0, 0);
    // reads
    add_vec(2'b10, 2'b00, 2'b00, 0,    0,         40,   0,     2'b10, 0, 40,   1, 1, 0,     0, 0);
    add_vec(2'b00, 2'b00, 2'b00, 0,    0,         0,    0,     2'b00, 0, 0,    1, 1, 32'h2, 0, 0);
    add_vec(2'b01, 2'b00, 2'b00, 28,   0,         0,    0,     2'b01, 0, 28,   0, 0, 0,     0, 0);
    add_vec(2'b00, 2'b00, 2'b00, 0,    0,         0,    0,     2'b00, 0, 0,    1, 0, 32'h5, 0, 0);
    add_vec(2'b10, 2'b00, 2'b00, 0,    0,         40,   0,     2'b10, 0, 40,   0, 0, 0,     0, 0);
    // locked burst of 4 from port 0, clean release on the last beat
    add_vec(2'b11, 2'b01, 2'b01, 100,  32'hA0,    40,   0,     2'b01, 1, 100,  1, 1, 32'h2, 0, 0);
    add_vec(2'b11, 2'b01, 2'b01, 101,  32'hA1,    40,   0,     2'b01, 1, 101,  1, 0, 0,     0, 0);
    add_vec(2'b11, 2'b01, 2'b01, 102,  32'hA2,    40,   0,     2'b01, 1, 102,  1, 0, 0,     0, 0);
    add_vec(2'b11, 2'b01, 2'b00, 103,  32'hA3,    40,   0,     2'b01, 1, 103,  1, 0, 0,     0, 0);
    add_vec(2'b11, 2'b01, 2'b00, 104,  32'hC4,    40,   0,     2'b10, 0, 40,   1, 0, 0,     0, 0);
    add_vec(2'b00, 2'b00, 2'b00, 0,    0,         0,    0,     2'b00, 0, 0,    1, 1, 32'h2, 0, 0);
    // port 0 never drops lock: watchdog after 4 beats
    add_vec(2'b11, 2'b01, 2'b01, 200,  32'hB0,    40,   0,     2'b01, 1, 200,  0, 0, 0,     0, 0);
    add_vec(2'b11, 2'b01, 2'b01, 201,  32'hB1,    40,   0,     2'b01, 1, 201,  1, 0, 0,     0, 0);
    add_vec(2'b11, 2'b01, 2'b01, 202,  32'hB2,    40,   0,     2'b01, 1, 202,  1, 0, 0,     0, 0);
    add_vec(2'b11, 2'b01, 2'b01, 203,  32'hB3,    40,   0,     2'b01, 1, 203,  1, 0, 0,     0, 0);
    add_vec(2'b11, 2'b01, 2'b01, 204,  32'hB4,    40,   0,     2'b10, 0, 40,   1, 0, 0,     0, 1);
    add_vec(2'b00, 2'b00, 2'b00, 0,    0,         0,    0,     2'b00, 0, 0,    1, 1, 32'h2, 0, 0);
    // owner locks then goes idle: port 1 blocked until watchdog fires
    add_vec(2'b01, 2'b00, 2'b01, 28,   0,         40,   0,     2'b01, 0, 28,   0, 0, 0,     0, 0);
    add_vec(2'b10, 2'b00, 2'b00, 28,   0,         40,   0,     2'b00, 0, 0,    1, 0, 32'h5, 0, 0);
    add_vec(2'b10, 2'b00, 2'b00, 28,   0,         40,   0,     2'b00, 0, 0,    0, 0, 0,     0, 0);
    add_vec(2'b10, 2'b00, 2'b00, 28,   0,         40,   0,     2'b00, 0, 0,    0, 0, 0,     0, 0);
    add_vec(2'b10, 2'b00, 2'b00, 28,   0,         40,   0,     2'b10, 0, 40,   0, 0, 0,     0, 1);
    add_vec(2'b00, 2'b00, 2'b00, 0,    0,         0,    0,     2'b00, 0, 0,    1, 1, 32'h2, 0, 0);
    // address range boundaries
    add_vec(2'b01, 2'b01, 2'b00, 1024, 32'hDEAD,  0,    0,     2'b01, 0, 1024, 0, 0, 0,     0, 0);
    add_vec(2'b00, 2'b00, 2'b00, 0,    0,         0,    0,     2'b00, 0, 0,    1, 0, 0,     1, 0);
    add_vec(2'b10, 2'b00, 2'b00, 0,    0,         2000, 0,     2'b10, 0, 2000, 0, 0, 0,     0, 0);
    add_vec(2'b00, 2'b00, 2'b00, 0,    0,         0,    0,     2'b00, 0, 0,    1, 1, 0,     1, 0);
    add_vec(2'b01, 2'b01, 2'b00, 1023, 32'h77,    0,    0,     2'b01, 1, 1023, 0, 0, 0,     0, 0);
    add_vec(2'b00, 2'b00, 2'b00, 0,    0,         0,    0,     2'b00, 0, 0,    1, 0, 0,     0, 0);

    // reset held with both ports requesting
    rst = 1'b1;
    req_valid = 2'b11; req_we = 2'b11; req_lock = 2'b00;
    req_addr0 = 28; req_addr1 = 40; req_wdata0 = 32'h1; req_wdata1 = 32'h2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_output("reset ready", 32'(req_ready), 32'h0);
    check_output("reset mem_we", 32'(mem_we), 32'h0);
    check_output("reset mem_a", mem_a, 32'h0);
    check_output("reset rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("reset lock_abort", 32'(lock_abort), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = 1'b0;
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("v%0d ready", i), 32'(req_ready), 32'(vecs[i].ready));
      check_output($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].mwe));
      check_output($sformatf("v%0d mem_a", i), mem_a, vecs[i].ma);
      check_output($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].rv));
      check_output($sformatf("v%0d lock_abort", i), 32'(lock_abort), 32'(vecs[i].abort));
      if (vecs[i].rv) begin
        check_output($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(vecs[i].rid));
        check_output($sformatf("v%0d rsp_rdata", i), rsp_rdata, vecs[i].rdata);
        check_output($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(vecs[i].rerr));
      end
    end

    @(negedge clk);
    check_output("mem[28]", mem[28], 32'h5);
    check_output("mem[40]", mem[40], 32'h2);
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("mem[%0d]", 100 + k), mem[100 + k], 32'hA0 + 32'(k));
      check_output($sformatf("mem[%0d]", 200 + k), mem[200 + k], 32'hB0 + 32'(k));
    end
    check_output("mem[104]", mem[104], 32'h0);
    check_output("mem[204]", mem[204], 32'h0);
    check_output("mem[1023]", mem[1023], 32'h77);
    check_output("mem[0]", mem[0], 32'h0);

    // reset in the middle of a port 1 locked burst
    req_valid = 2'b10; req_we = 2'b00; req_lock = 2'b10; req_addr1 = 40;
    #1;
    check_output("burst start ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b11; req_lock = 2'b00; req_addr0 = 28;
    #1;
    check_output("midburst rst ready", 32'(req_ready), 32'h0);
    check_output("midburst rst mem_we", 32'(mem_we), 32'h0);
    check_output("midburst rst mem_a", mem_a, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("post rst rsp_valid", 32'(rsp_valid), 32'h0);
    check_output("post rst ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check_output("post rst rsp_valid2", 32'(rsp_valid), 32'h1);
    check_output("post rst rsp_id", 32'(rsp_id), 32'h0);
    check_output("post rst rsp_rdata", rsp_rdata, 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
